wishbone_master_adapter: RTL
============================

# wishbone_master_adapter

Converts single-word load/store requests from the RV32I core's data port into Wishbone classic single-read/single-write cycles. It sits directly upstream of the Wishbone slave adapter that fronts the RAM. It holds one outstanding transaction, registers read data on ACK, and returns a one-cycle completion pulse to the core. An optional bus timeout aborts cycles that never receive ACK.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; SEL width = DATA_W/8
- TIMEOUT_CYCLES, 255, cycles in BUS without ACK before abort (only with timeout compiled in)

Ports:
- clk_i  in  1  clock, rising edge
- rst  in  1  reset: synchronous, active-high, on clk_i
- core_req_i  in  1  request strobe; sampled only in IDLE
- core_we_i  in  1  1 = store, 0 = load
- core_addr_i  in  ADDR_W  byte address
- core_wdata_i  in  DATA_W  store data
- core_sel_i  in  DATA_W/8  byte enables
- core_busy_o  out  1  high whenever state ≠ IDLE
- core_ready_o  out  1  one-cycle completion pulse
- core_rdata_o  out  DATA_W  load data; valid while core_ready_o=1
- core_err_o  out  1  timeout abort flag; valid only with core_ready_o
- wb_addr_o  out  ADDR_W  Wishbone address
- wb_data_o  out  DATA_W  Wishbone write data
- wb_data_i  in  DATA_W  Wishbone read data
- wb_we_o  out  1  Wishbone write enable
- wb_sel_o  out  DATA_W/8  Wishbone byte select
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_ack_i  in  1  Wishbone acknowledge

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - On core_req_i=1, latch addr, wdata, we and sel into output registers and go to BUS.
  - Otherwise stay in IDLE.
- BUS:
  - wb_cyc_o = wb_stb_o = 1. Address, data, we and sel are held stable from the latch.
  - On wb_ack_i=1: register wb_data_i into core_rdata_o (load only; a store leaves rdata at 0), clear err, go to RESP.
- RESP:
  - cyc and stb are 0, core_ready_o = 1, then go to IDLE.
- The adapter accepts no new request outside IDLE. core_req_i held high across completion is treated as a new request in the following IDLE cycle.
- Boundary conditions:
  - wb_ack_i in IDLE or RESP is ignored.
  - If ACK arrives in the same cycle the timeout reaches its terminal count, ACK wins: normal completion with err=0.
  - rst in any state forces IDLE on the next edge and drops cyc/stb. No ready pulse is issued for the aborted transaction.
- Reset values: every output is 0, including wb_addr_o, wb_data_o, wb_sel_o and core_rdata_o.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- Cycle sequence:
  - Cycle 0: core_req_i sampled.
  - Cycle 1: cyc/stb high.
  - The downstream slave ACKs in cycle 2.
  - Cycle 3: RESP with core_ready_o=1 and cyc/stb low.
  - Cycle 4: IDLE.
- Request-to-ready latency is 3 cycles against the one-wait-state slave. In general it is (cycles until ACK) + 1.
- The RESP cycle plus the return to IDLE guarantee at least 2 bus-idle cycles between transactions. This covers the slave's cooldown state.
- Back-to-back throughput is one transaction per 4 cycles.

## Configuration
- Macro WB_MASTER_TIMEOUT_EN.
- When defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to BUS and increments each BUS cycle without ACK.
  - When the count reaches TIMEOUT_CYCLES with no ACK, go to RESP with core_err_o=1 and core_rdata_o=0.
- When undefined:
  - No counter; BUS waits indefinitely for ACK.
  - core_err_o is tied to 0.

## Structure
- Shared package wb_pkg contains:
  - FSM state encoding localparams (IDLE=2'b00, BUS=2'b01, RESP=2'b10).
  - The default ADDR_W/DATA_W constants, shared with the slave adapter.
- One sub-module, wb_timeout_counter (enable, clear, terminal-count output). It is instantiated only under WB_MASTER_TIMEOUT_EN.

## Test plan
- Store: addr 0x0000_0010, wdata 0xDEADBEEF, sel 4'hF, slave ACKs in cycle 2 → wb_we_o=1 with stable addr/data during BUS; ready pulse in cycle 3; err=0; cyc low in cycle 3.
- Load: addr 0x10, slave returns 0xDEADBEEF with ACK → core_rdata_o=0xDEADBEEF exactly in the ready cycle; cyc/stb high for exactly 2 cycles.
- Back-to-back: core_req_i held high for 3 requests → ready pulses 4 cycles apart; cyc low for at least 2 cycles between bus cycles; core_busy_o low only in IDLE.
- Timeout (macro on, TIMEOUT_CYCLES=8, ACK never asserted) → cyc drops after 8 BUS cycles; ready=1, err=1, rdata=0; next request completes normally with err=0.
- Reset mid-BUS: rst asserted for 1 cycle while cyc=1 → all outputs 0 next cycle; no ready pulse; late ACK is ignored.
- Spurious ACK in IDLE and in RESP → no state change and no extra ready pulse.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: FSM encoding and default bus widths used by the
// master and slave adapters.
package wb_pkg;

    localparam int unsigned WB_ADDR_W = 32;
    localparam int unsigned WB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        RESP = 2'b10
    } wb_state_e;

endpackage : wb_pkg

// File: rtl/wb_timeout_counter.sv
// Bus-cycle watchdog: counts enabled cycles and flags the one whose increment
// reaches TIMEOUT_CYCLES.
module wb_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk_i) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    // Terminal when this cycle's increment would bring the count to TIMEOUT_CYCLES.
    assign tc_c = en && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule : wb_timeout_counter

// File: rtl/wishbone_master_adapter.sv
// Core data-port to Wishbone classic single-cycle master, one outstanding
// transaction. Define WB_MASTER_TIMEOUT_EN to abort cycles that never see ACK.
module wishbone_master_adapter
    import wb_pkg::*;
#(
    parameter int unsigned ADDR_W         = WB_ADDR_W,
    parameter int unsigned DATA_W         = WB_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk_i,
    input  logic                rst,
    input  logic                core_req_i,
    input  logic                core_we_i,
    input  logic [ADDR_W-1:0]   core_addr_i,
    input  logic [DATA_W-1:0]   core_wdata_i,
    input  logic [DATA_W/8-1:0] core_sel_i,
    output logic                core_busy_o,
    output logic                core_ready_o,
    output logic [DATA_W-1:0]   core_rdata_o,
    output logic                core_err_o,
    output logic [ADDR_W-1:0]   wb_addr_o,
    output logic [DATA_W-1:0]   wb_data_o,
    input  logic [DATA_W-1:0]   wb_data_i,
    output logic                wb_we_o,
    output logic [DATA_W/8-1:0] wb_sel_o,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    input  logic                wb_ack_i
);

    wb_state_e state;
    logic      timeout_c;

`ifdef WB_MASTER_TIMEOUT_EN
    wb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i (clk_i),
        .rst   (rst),
        .clr   (state != BUS),
        .en    ((state == BUS) && !wb_ack_i),
        .tc_c  (timeout_c)
    );
`else
    assign timeout_c = 1'b0;
`endif

    // Control FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            state        <= IDLE;
            core_busy_o  <= 1'b0;
            core_ready_o <= 1'b0;
            core_rdata_o <= '0;
            core_err_o   <= 1'b0;
            wb_addr_o    <= '0;
            wb_data_o    <= '0;
            wb_we_o      <= 1'b0;
            wb_sel_o     <= '0;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
        end else begin
            core_ready_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (core_req_i) begin
                        wb_addr_o   <= core_addr_i;
                        wb_data_o   <= core_wdata_i;
                        wb_we_o     <= core_we_i;
                        wb_sel_o    <= core_sel_i;
                        wb_cyc_o    <= 1'b1;
                        wb_stb_o    <= 1'b1;
                        core_busy_o <= 1'b1;
                        state       <= BUS;
                    end
                end
                BUS: begin
                    // ACK takes priority over a coincident timeout.
                    if (wb_ack_i) begin
                        core_rdata_o <= wb_we_o ? '0 : wb_data_i;
                        core_err_o   <= 1'b0;
                        core_ready_o <= 1'b1;
                        wb_cyc_o     <= 1'b0;
                        wb_stb_o     <= 1'b0;
                        state        <= RESP;
                    end else if (timeout_c) begin
                        core_rdata_o <= '0;
                        core_err_o   <= 1'b1;
                        core_ready_o <= 1'b1;
                        wb_cyc_o     <= 1'b0;
                        wb_stb_o     <= 1'b0;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    core_busy_o <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    core_busy_o <= 1'b0;
                    wb_cyc_o    <= 1'b0;
                    wb_stb_o    <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule : wishbone_master_adapter
